// File: rtl/tpu_pkg.sv
// Shared encodings for the TPU instruction sequencer: opcodes, FSM states
// and the one-hot decoded-operation record.
package tpu_pkg;

  typedef enum logic [2:0] {
    OP_NOP         = 3'b000,
    OP_LOAD_ADDR   = 3'b001,
    OP_LOAD_WEIGHT = 3'b010,
    OP_LOAD_INPUTS = 3'b011,
    OP_VALID       = 3'b100,
    OP_STORE       = 3'b101,
    OP_LOOP        = 3'b110,
    OP_HALT        = 3'b111
  } opcode_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef struct packed {
    logic nop;
    logic load_addr;
    logic load_weight;
    logic load_inputs;
    logic valid;
    logic store;
    logic loop;
    logic halt;
  } op_flags_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory and datapath-command bus between the sequencer and the
// rest of the TPU.
interface instr_sequencer_if #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 13,
  parameter int PC_W    = 8
);
  // Handshake: the sequencer raises exactly one command pulse (load_weight,
  // load_input, valid or store) for a single cycle, then issues nothing more
  // until it samples dp_ready=1 on a later rising edge. imem_data must present
  // the word at imem_addr one cycle after the address was driven.
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               dp_ready;
  logic [ADDR_W-1:0]  base_address;
  logic               load_weight;
  logic               load_input;
  logic               valid;
  logic               store;
  logic               busy;
  logic               halted;

  modport master (
    output imem_addr, base_address, load_weight, load_input, valid, store,
           busy, halted,
    input  imem_data, dp_ready
  );

  modport slave (
    input  imem_addr, base_address, load_weight, load_input, valid, store,
           busy, halted,
    output imem_data, dp_ready
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational opcode decode into one-hot operation flags.
module instr_decoder
  import tpu_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] opcode,
  output op_flags_t       flags
);

  // Any encoding outside the defined set behaves as a NOP.
  always_comb begin
    flags = '0;
    case (opcode)
      OP_W'(OP_LOAD_ADDR):   flags.load_addr   = 1'b1;
      OP_W'(OP_LOAD_WEIGHT): flags.load_weight = 1'b1;
      OP_W'(OP_LOAD_INPUTS): flags.load_inputs = 1'b1;
      OP_W'(OP_VALID):       flags.valid       = 1'b1;
      OP_W'(OP_STORE):       flags.store       = 1'b1;
      OP_W'(OP_LOOP):        flags.loop        = 1'b1;
      OP_W'(OP_HALT):        flags.halt        = 1'b1;
      default:               flags.nop         = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from a synchronous instruction memory and
// issues single-cycle datapath commands, with one level of counted looping.
module instr_sequencer
  import tpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 3,
  parameter int ADDR_W  = 13,
  parameter int PC_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_sequencer_if.master   bus,
  output logic [2:0]          state_dbg,
  output logic                loop_active_dbg
);

  localparam int LCNT_W = ADDR_W - PC_W;

  logic [2:0]        state;
  logic [PC_W-1:0]   pc;
  logic [ADDR_W-1:0] base_q;
  logic [LCNT_W-1:0] loop_cnt;
  logic              loop_active;
  op_flags_t         op;
  logic              cmd;
  logic              in_exec;
  logic [PC_W-1:0]   loop_target;
  logic [LCNT_W-1:0] loop_count;

  instr_decoder #(.OP_W(OP_W)) u_decoder (
    .opcode (bus.imem_data[INSTR_W-1 -: OP_W]),
    .flags  (op)
  );

  assign loop_target = bus.imem_data[PC_W-1:0];
  assign loop_count  = bus.imem_data[ADDR_W-1:PC_W];
  assign cmd         = op.load_weight | op.load_inputs | op.valid | op.store;
  assign in_exec     = (state == ST_EXEC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      base_q      <= '0;
      loop_cnt    <= '0;
      loop_active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state       <= ST_FETCH;
            pc          <= '0;
            loop_cnt    <= '0;
            loop_active <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          if (op.halt) begin
            state <= ST_HALT;
          end else begin
            state <= cmd ? ST_WAIT : ST_FETCH;
            if (op.load_addr) base_q <= bus.imem_data[ADDR_W-1:0];
            if (op.nop || op.load_addr || cmd) pc <= pc + PC_W'(1);
            // Single loop level: the first LOOP arms the counter, later
            // visits count it down, and the last visit falls through.
            if (op.loop) begin
              if (!loop_active) begin
                if (loop_count != '0) begin
                  loop_active <= 1'b1;
                  loop_cnt    <= loop_count - LCNT_W'(1);
                  pc          <= loop_target;
                end else begin
                  pc <= pc + PC_W'(1);
                end
              end else if (loop_cnt != '0) begin
                loop_cnt <= loop_cnt - LCNT_W'(1);
                pc       <= loop_target;
              end else begin
                loop_active <= 1'b0;
                pc          <= pc + PC_W'(1);
              end
            end
          end
        end
        ST_WAIT: if (bus.dp_ready) state <= ST_FETCH;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.base_address = base_q;
  assign bus.load_weight  = in_exec & op.load_weight;
  assign bus.load_input   = in_exec & op.load_inputs;
  assign bus.valid        = in_exec & op.valid;
  assign bus.store        = in_exec & op.store;
  assign bus.busy         = (state != ST_IDLE) && (state != ST_HALT);
  assign bus.halted       = (state == ST_HALT);

  assign state_dbg       = state;
  assign loop_active_dbg = loop_active;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level program
// interpreter predicts every command pulse and the final halt state.
module tb_instr_sequencer;
  import tpu_pkg::*;

  localparam int W = 23;  // {kind[1:0], base_address[12:0], pc[7:0]}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] state_dbg;
  logic       loop_active_dbg;

  instr_sequencer_if #(.INSTR_W(16), .ADDR_W(13), .PC_W(8)) bus ();

  instr_sequencer #(.INSTR_W(16), .OP_W(3), .ADDR_W(13), .PC_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .bus             (bus),
    .state_dbg       (state_dbg),
    .loop_active_dbg (loop_active_dbg)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [12:0]  model_base = '0;
  int checks = 0;
  int failures = 0;
  int valid_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Instruction-level interpreter of the program held in mem.
  task automatic model_run(output int fin_pc, output bit fin_la);
    int pc, lc, steps;
    bit la, done;
    logic [15:0] ins;
    logic [1:0]  kind;
    pc = 0; lc = 0; la = 0; done = 0; steps = 0;
    while (!done && steps < 4000) begin
      ins = mem[pc];
      steps++;
      case (ins[15:13])
        3'd1: begin model_base = ins[12:0]; pc = (pc + 1) % 256; end
        3'd2, 3'd3, 3'd4, 3'd5: begin
          kind = 2'(ins[15:13] - 3'd2);
          exp_q.push_back({kind, model_base, 8'(pc)});
          pc = (pc + 1) % 256;
        end
        3'd6: begin
          if (!la) begin
            if (ins[12:8] == 5'd0) pc = (pc + 1) % 256;
            else begin la = 1; lc = int'(ins[12:8]) - 1; pc = int'(ins[7:0]); end
          end else if (lc > 0) begin
            lc--; pc = int'(ins[7:0]);
          end else begin
            la = 0; pc = (pc + 1) % 256;
          end
        end
        3'd7: done = 1;
        default: pc = (pc + 1) % 256;
      endcase
    end
    fin_pc = pc;
    fin_la = la;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int n;
    logic [1:0]   kind;
    logic [W-1:0] exp;
    n = int'(bus.load_weight) + int'(bus.load_input) + int'(bus.valid) + int'(bus.store);
    if (n != 0) begin
      check("pulse_onehot", n, 1);
      if (bus.valid) valid_seen++;
      kind = bus.load_input ? 2'd1 : bus.valid ? 2'd2 : bus.store ? 2'd3 : 2'd0;
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", {kind, bus.base_address, bus.imem_addr}, '1);
      end else begin
        exp = exp_q.pop_front();
        check("pulse", {kind, bus.base_address, bus.imem_addr}, exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    model_base = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_and_check(input string name, input int budget, input bit rand_ready,
                               output int cyc);
    int fin_pc;
    bit fin_la;
    model_run(fin_pc, fin_la);
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (rand_ready) bus.dp_ready = ($urandom_range(0, 3) != 0);
    end while (!bus.halted && cyc < budget);
    bus.dp_ready = 1'b1;
    check({name, "_halted"}, bus.halted, 1);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_pc"}, bus.imem_addr, fin_pc);
    check({name, "_base"}, bus.base_address, model_base);
    check({name, "_loop_active"}, loop_active_dbg, fin_la);
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_store(input string name);
    int n = 0;
    while (!bus.store && n < 20) begin @(negedge clk); start = 1'b0; n++; end
    check({name, "_store_seen"}, bus.store, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, len, p, fin_pc;
    bit fin_la;
    bus.dp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_pc", bus.imem_addr, 0);
    check("rst_base", bus.base_address, 0);
    check("rst_flags", {bus.busy, bus.halted, bus.load_weight, bus.load_input, bus.valid, bus.store}, 0);
    reset = 1'b0;
    @(negedge clk);

    // LOAD_ADDR 0x40, LOAD_WEIGHT, HALT
    mem[0] = 16'h2040; mem[1] = 16'h4000; mem[2] = 16'hE000;
    run_and_check("basic", 50, 0, cyc);
    check("basic_cycles", cyc, 8);
    check("basic_base_abs", bus.base_address, 13'h040);

    // STORE stalled by dp_ready low for five cycles
    mem[0] = 16'hA000; mem[1] = 16'hE000;
    model_run(fin_pc, fin_la);
    bus.dp_ready = 1'b0;
    start = 1'b1;
    wait_store("stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_busy", bus.busy, 1);
      check("stall_pc", bus.imem_addr, 1);
      check("stall_state", state_dbg, ST_WAIT);
    end
    bus.dp_ready = 1'b1;
    cyc = 0;
    while (!bus.halted && cyc < 20) begin @(negedge clk); cyc++; end
    check("stall_halted", bus.halted, 1);
    check("stall_pending", exp_q.size(), 0);

    // VALID body looped count=3 -> four passes
    mem[0] = 16'h8000; mem[1] = 16'hC300; mem[2] = 16'hE000;
    valid_seen = 0;
    run_and_check("loop", 200, 1, cyc);
    check("loop_valid_count", valid_seen, 4);

    // LOOP with count 0 falls through
    mem[0] = 16'hC005; mem[1] = 16'h8000; mem[2] = 16'hE000;
    valid_seen = 0;
    run_and_check("loop0", 100, 0, cyc);
    check("loop0_valid_count", valid_seen, 1);
    check("loop0_pc", bus.imem_addr, 2);

    // Reset while waiting on dp_ready
    mem[0] = 16'hA000; mem[1] = 16'hE000;
    mem[2] = 16'h0000;
    model_run(fin_pc, fin_la);
    bus.dp_ready = 1'b0;
    start = 1'b1;
    wait_store("rstw");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstw_state", state_dbg, ST_IDLE);
    check("rstw_pc", bus.imem_addr, 0);
    check("rstw_base", bus.base_address, 0);
    check("rstw_flags", {bus.busy, bus.halted, bus.load_weight, bus.load_input, bus.valid, bus.store}, 0);
    exp_q.delete();
    model_base = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstw_release_state", state_dbg, ST_IDLE);
    bus.dp_ready = 1'b1;
    run_and_check("rstw_rerun", 50, 0, cyc);

    // 256 NOPs, no HALT: pc must wrap and keep executing
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    start = 1'b1;
    cyc = 0;
    do begin @(negedge clk); start = 1'b0; cyc++; end
    while (bus.imem_addr != 8'd255 && cyc < 1000);
    check("wrap_reach_255", bus.imem_addr, 255);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.imem_addr == 8'd255 && cyc < 10);
    check("wrap_to_0", bus.imem_addr, 0);
    check("wrap_busy", bus.busy, 1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.imem_addr == 8'd0 && cyc < 10);
    check("wrap_continue", bus.imem_addr, 1);
    do_reset();

    // Randomised programs: filler commands, at most one LOOP, final HALT
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(3, 20);
      for (int i = 0; i < len; i++)
        mem[i] = {3'($urandom_range(0, 5)), 13'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, len - 1);
        mem[p] = {3'd6, 5'($urandom_range(0, 4)), 8'($urandom_range(0, p))};
      end
      mem[len] = 16'hE000;
      run_and_check($sformatf("rand%0d", t), 3000, 1, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
